// File: rtl/sb_tx_serializer.sv
// Sideband TX serializer: latches one header (+ optional payload) per handshake,
// fills parity, and shifts 64-UI phits LSB first with GAP_UI idle UI after each.
module sb_tx_serializer #(
   parameter int unsigned GAP_UI     = 32,
   parameter bit          GEN_PARITY = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_valid,
   output logic        tx_ready,
   input  logic [63:0] tx_hdr,
   input  logic        tx_expect_32b,
   input  logic        tx_expect_64b,
   input  logic [63:0] tx_data,
   output logic        sb_tx_data,
   output logic        sb_tx_valid,
   output logic        busy,
   output logic        pkt_done,
   output logic        flag_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_GAP_H,
      S_DATA,
      S_GAP_D
   } state_t;

   localparam logic [7:0] PHIT_LAST = 8'd63;
   localparam logic [7:0] GAP_LAST  = 8'(GAP_UI - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [63:0] hdr_q, hdr_d;
   logic [63:0] data_q, data_d;
   logic        has_pl_q, has_pl_d;

   logic        final_gap;
   logic        last_gap;
   logic        accept;
   logic [63:0] payload;
   logic [63:0] hdr_par;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         hdr_q    <= '0;
         data_q   <= '0;
         has_pl_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hdr_q    <= hdr_d;
         data_q   <= data_d;
         has_pl_q <= has_pl_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 8'd1;
      hdr_d    = hdr_q;
      data_d   = data_q;
      has_pl_d = has_pl_q;

      // GAP_H is the final gap only for header-only packets
      final_gap = ((state_q == S_GAP_H) && !has_pl_q) || (state_q == S_GAP_D);
      last_gap  = final_gap && (cnt_q == GAP_LAST);
      tx_ready  = !rst && ((state_q == S_IDLE) || last_gap);
      accept    = tx_valid && tx_ready;

      if (tx_expect_64b) begin
         payload = tx_data;
      end else if (tx_expect_32b) begin
         payload = {32'h0, tx_data[31:0]};
      end else begin
         payload = '0;
      end

      hdr_par = tx_hdr;
      if (GEN_PARITY) begin
         hdr_par[62] = ^tx_hdr[61:0];
         hdr_par[63] = ^payload;
      end

      case (state_q)
         S_IDLE: cnt_d = '0;
         S_HDR: begin
            if (cnt_q == PHIT_LAST) begin
               state_d = S_GAP_H;
               cnt_d   = '0;
            end
         end
         S_GAP_H: begin
            if ((cnt_q == GAP_LAST) && has_pl_q) begin
               state_d = S_DATA;
               cnt_d   = '0;
            end
         end
         S_DATA: begin
            if (cnt_q == PHIT_LAST) begin
               state_d = S_GAP_D;
               cnt_d   = '0;
            end
         end
         default: ;
      endcase

      if (last_gap) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end

      // accept only happens in IDLE or on the last final-gap cycle; both lead to HDR
      if (accept) begin
         state_d  = S_HDR;
         cnt_d    = '0;
         hdr_d    = hdr_par;
         data_d   = payload;
         has_pl_d = tx_expect_32b || tx_expect_64b;
      end

      sb_tx_valid = (state_q == S_HDR) || (state_q == S_DATA);
      if (state_q == S_HDR) begin
         sb_tx_data = hdr_q[cnt_q[5:0]];
      end else if (state_q == S_DATA) begin
         sb_tx_data = data_q[cnt_q[5:0]];
      end else begin
         sb_tx_data = 1'b0;
      end
      busy     = (state_q != S_IDLE);
      pkt_done = last_gap;
      flag_err = accept && tx_expect_32b && tx_expect_64b;
   end

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Directed bench for sb_tx_serializer: vector table of packets with
// hand-computed parity, plus back-to-back and mid-packet reset sequences.
module tb_sb_tx_serializer;

   logic        clk;
   logic        rst;
   logic        tx_valid;
   logic        tx_ready;
   logic [63:0] tx_hdr;
   logic        tx_expect_32b;
   logic        tx_expect_64b;
   logic [63:0] tx_data;
   logic        sb_tx_data;
   logic        sb_tx_valid;
   logic        busy;
   logic        pkt_done;
   logic        flag_err;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   sb_tx_serializer #(
      .GAP_UI    (32),
      .GEN_PARITY(1'b1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .tx_hdr       (tx_hdr),
      .tx_expect_32b(tx_expect_32b),
      .tx_expect_64b(tx_expect_64b),
      .tx_data      (tx_data),
      .sb_tx_data   (sb_tx_data),
      .sb_tx_valid  (sb_tx_valid),
      .busy         (busy),
      .pkt_done     (pkt_done),
      .flag_err     (flag_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] hdr;
      logic [63:0] data;
      logic        e32;
      logic        e64;
      logic [63:0] exp_hdr;
      logic [63:0] exp_data;
      logic        has_pl;
      logic        ferr;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      logic [63:0] hw = '0;
      logic [63:0] dw = '0;
      int unsigned total;
      int unsigned valid_bad = 0;
      int unsigned gap_bad = 0;
      int unsigned busy_bad = 0;
      int unsigned ferr_bad = 0;
      int unsigned done_cnt = 0;
      int unsigned done_at = 0;
      logic exp_v;
      @(negedge clk);
      tx_hdr = v.hdr;
      tx_data = v.data;
      tx_expect_32b = v.e32;
      tx_expect_64b = v.e64;
      tx_valid = 1'b1;
      #1;
      chk("ready_pre", tx_ready, 1);
      chk("flag_err_accept", flag_err, v.ferr);
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      tx_hdr = ~v.hdr;
      tx_data = ~v.data;
      tx_expect_32b = ~v.e32;
      tx_expect_64b = ~v.e64;
      total = v.has_pl ? 192 : 96;
      for (int i = 0; i < int'(total); i++) begin
         @(negedge clk);
         exp_v = (i < 64) || (v.has_pl && i >= 96 && i < 160);
         if (sb_tx_valid !== exp_v) valid_bad++;
         if (exp_v) begin
            if (i < 64) hw[i] = sb_tx_data;
            else dw[i-96] = sb_tx_data;
         end else if (sb_tx_data !== 1'b0) begin
            gap_bad++;
         end
         if (busy !== 1'b1) busy_bad++;
         if (flag_err !== 1'b0) ferr_bad++;
         if (pkt_done === 1'b1) begin
            done_cnt++;
            done_at = i;
         end
      end
      chk("hdr_phit", hw, v.exp_hdr);
      if (v.has_pl) chk("data_phit", dw, v.exp_data);
      chk("valid_pattern_errs", valid_bad, 0);
      chk("gap_nonzero_errs", gap_bad, 0);
      chk("busy_drop_errs", busy_bad, 0);
      chk("flag_err_spurious", ferr_bad, 0);
      chk("pkt_done_count", done_cnt, 1);
      chk("pkt_done_cycle", done_at, total - 1);
      @(negedge clk);
      chk("busy_after", busy, 0);
      chk("ready_after", tx_ready, 1);
   endtask

   initial begin
      logic [63:0] hw_a;
      logic [63:0] hw_b;
      int unsigned valid_bad;
      int unsigned gap_bad;
      int unsigned busy_bad;
      int unsigned ready_bad;
      int unsigned done_bad;
      int unsigned pd_cnt;
      logic exp_v;

      vecs[0] = '{64'h0000_0000_0024_4012, 64'h0, 1'b0, 1'b0,
                  64'h4000_0000_0024_4012, 64'h0, 1'b0, 1'b0};
      vecs[1] = '{64'h0000_0000_0024_4012, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1,
                  64'h4000_0000_0024_4012, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0};
      vecs[2] = '{64'hC000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                  64'h4000_0000_0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0};
      vecs[3] = '{64'h0000_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
                  64'h0000_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      vecs[4] = '{64'h0000_0000_0000_0000, 64'hFFFF_FFFF_0000_0001, 1'b1, 1'b0,
                  64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b1, 1'b0};
      vecs[5] = '{64'h8000_0000_0000_0000, 64'h1234_5678_1234_5678, 1'b0, 1'b0,
                  64'h0000_0000_0000_0000, 64'h0, 1'b0, 1'b0};

      rst = 1'b0;
      tx_valid = 1'b0;
      tx_hdr = '0;
      tx_data = '0;
      tx_expect_32b = 1'b0;
      tx_expect_64b = 1'b0;

      // Reset raised before the first clock edge
      #2 rst = 1'b1;
      #1;
      chk("rst_sb_tx_valid", sb_tx_valid, 0);
      chk("rst_sb_tx_data", sb_tx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pkt_done", pkt_done, 0);
      chk("rst_flag_err", flag_err, 0);
      chk("rst_tx_ready", tx_ready, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_tx_ready", tx_ready, 1);
      chk("rel_busy", busy, 0);

      for (int k = 0; k < 6; k++) run_vec(vecs[k]);

      // Back-to-back: valid held, second accept on the last gap cycle
      @(negedge clk);
      tx_hdr = 64'h0000_0000_0024_4012;
      tx_data = '0;
      tx_expect_32b = 1'b0;
      tx_expect_64b = 1'b0;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_hdr = 64'h0000_0000_0000_0007;
      hw_a = '0; hw_b = '0;
      valid_bad = 0; gap_bad = 0; busy_bad = 0; ready_bad = 0; done_bad = 0;
      for (int i = 0; i < 192; i++) begin
         @(negedge clk);
         exp_v = (i < 64) || (i >= 96 && i < 160);
         if (sb_tx_valid !== exp_v) valid_bad++;
         if (exp_v) begin
            if (i < 64) hw_a[i] = sb_tx_data;
            else hw_b[i-96] = sb_tx_data;
         end else if (sb_tx_data !== 1'b0) begin
            gap_bad++;
         end
         if (busy !== 1'b1) busy_bad++;
         if (pkt_done !== ((i == 95) || (i == 191))) done_bad++;
         if (i < 95 && tx_ready !== 1'b0) ready_bad++;
         if (i == 95) begin
            chk("b2b_ready_last_gap", tx_ready, 1);
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
            tx_hdr = 64'hFFFF_FFFF_FFFF_FFFF;
         end
      end
      chk("b2b_hdr_a", hw_a, 64'h4000_0000_0024_4012);
      chk("b2b_hdr_b", hw_b, 64'h4000_0000_0000_0007);
      chk("b2b_valid_errs", valid_bad, 0);
      chk("b2b_gap_errs", gap_bad, 0);
      chk("b2b_busy_errs", busy_bad, 0);
      chk("b2b_pkt_done_errs", done_bad, 0);
      chk("b2b_ready_early_errs", ready_bad, 0);
      @(negedge clk);
      chk("b2b_busy_after", busy, 0);

      // Abort: reset raised during DATA UI 20
      @(negedge clk);
      tx_hdr = '0;
      tx_data = 64'hFFFF_FFFF_FFFF_FFFF;
      tx_expect_64b = 1'b1;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      tx_expect_64b = 1'b0;
      for (int i = 0; i <= 116; i++) @(negedge clk);
      chk("abort_pre_valid", sb_tx_valid, 1);
      chk("abort_pre_data", sb_tx_data, 1);
      #1 rst = 1'b1;
      #1;
      chk("abort_sb_tx_valid", sb_tx_valid, 0);
      chk("abort_sb_tx_data", sb_tx_data, 0);
      chk("abort_busy", busy, 0);
      chk("abort_pkt_done", pkt_done, 0);
      pd_cnt = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (pkt_done !== 1'b0 || busy !== 1'b0 || sb_tx_valid !== 1'b0) pd_cnt++;
      end
      chk("abort_quiet_errs", pd_cnt, 0);
      run_vec(vecs[1]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
